// File: rtl/vred_minmax_seq_if.sv
// Handshake/comparator bundle between lane controller, vred_minmax_seq and the comparator.
// elem_mask_i exists only when VRED_MASK_EN is defined.
interface vred_minmax_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int VL_W       = 6
);
  logic                  start_i;
  logic [6:0]            ocode_i;
  logic [VL_W-1:0]       vl_i;
  logic [DATA_WIDTH-1:0] scalar_i;
  logic                  elem_valid_i;
  logic                  elem_ready_o;
  logic [DATA_WIDTH-1:0] elem_data_i;
`ifdef VRED_MASK_EN
  logic                  elem_mask_i;
`endif
  logic                  cmp_en_o;
  logic [DATA_WIDTH-1:0] cmp_a_o;
  logic [DATA_WIDTH-1:0] cmp_b_o;
  logic [6:0]            cmp_ocode_o;
  logic [DATA_WIDTH-1:0] cmp_result_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  err_o;

  modport master (
    output start_i, ocode_i, vl_i, scalar_i, elem_valid_i, elem_data_i,
`ifdef VRED_MASK_EN
    output elem_mask_i,
`endif
    output cmp_result_i,
    input  elem_ready_o, cmp_en_o, cmp_a_o, cmp_b_o, cmp_ocode_o,
    input  busy_o, done_o, result_o, err_o
  );

  modport slave (
    input  start_i, ocode_i, vl_i, scalar_i, elem_valid_i, elem_data_i,
`ifdef VRED_MASK_EN
    input  elem_mask_i,
`endif
    input  cmp_result_i,
    output elem_ready_o, cmp_en_o, cmp_a_o, cmp_b_o, cmp_ocode_o,
    output busy_o, done_o, result_o, err_o
  );
endinterface

// File: rtl/vred_minmax_seq.sv
// Reduction sequencer for vredmin/vredminu/vredmax/vredmaxu over an external comparator.
// Optional element masking is compiled in with VRED_MASK_EN.
module vred_minmax_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int VL_W       = 6
) (
  input logic              module_clk_i,
  input logic              rst_i,
  vred_minmax_seq_if.slave bus
);
  // {op, INT} encodings mirrored from vect_pkg
  localparam logic [6:0] VMINU_VREDMINU = 7'h09;
  localparam logic [6:0] VMIN_VREDMIN   = 7'h0B;
  localparam logic [6:0] VMAXU_VREDMAXU = 7'h0D;
  localparam logic [6:0] VMAX_VREDMAX   = 7'h0F;

  localparam logic [VL_W-1:0]       VL_ZERO   = {VL_W{1'b0}};
  localparam logic [VL_W-1:0]       VL_ONE    = {{(VL_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [DATA_WIDTH-1:0] acc_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic [VL_W-1:0]       cnt_r;
  logic [VL_W-1:0]       vl_r;
  logic [6:0]            ocode_r;
  logic                  done_r;
  logic                  err_r;
  logic                  in_idle_s;
  logic                  in_accum_s;
  logic                  legal_s;
  logic                  start_ok_s;
  logic                  accept_s;
  logic                  active_s;
  logic                  last_s;

  function automatic logic is_legal(input logic [6:0] oc);
    case (oc)
      VMINU_VREDMINU, VMIN_VREDMIN, VMAXU_VREDMAXU, VMAX_VREDMAX: is_legal = 1'b1;
      default:                                                    is_legal = 1'b0;
    endcase
  endfunction

  // Handshake decode and comparator operand drive
  always_comb begin
    in_idle_s  = (state_r == IDLE);
    in_accum_s = (state_r == ACCUM);
    legal_s    = is_legal(bus.ocode_i);
    start_ok_s = in_idle_s & bus.start_i & legal_s;
`ifdef VRED_MASK_EN
    active_s   = bus.elem_mask_i;
`else
    active_s   = 1'b1;
`endif
    accept_s   = in_accum_s & bus.elem_valid_i;
    last_s     = (cnt_r == (vl_r - VL_ONE));

    bus.elem_ready_o = in_accum_s;
    bus.cmp_en_o     = accept_s & active_s;
    bus.busy_o       = ~in_idle_s;
    if (in_accum_s) begin
      bus.cmp_a_o     = acc_r;
      bus.cmp_b_o     = bus.elem_data_i;
      bus.cmp_ocode_o = ocode_r;
    end else begin
      bus.cmp_a_o     = DATA_ZERO;
      bus.cmp_b_o     = DATA_ZERO;
      bus.cmp_ocode_o = 7'd0;
    end
  end

  assign bus.done_o   = done_r;
  assign bus.err_o    = err_r;
  assign bus.result_o = result_r;

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          next_state_s = (bus.vl_i == VL_ZERO) ? DONE : ACCUM;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = ACCUM;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge module_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Accumulator, element counter and latched command
  always_ff @(posedge module_clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_r    <= DATA_ZERO;
      cnt_r    <= VL_ZERO;
      vl_r     <= VL_ZERO;
      ocode_r  <= 7'd0;
      result_r <= DATA_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            acc_r   <= bus.scalar_i;
            cnt_r   <= VL_ZERO;
            vl_r    <= bus.vl_i;
            ocode_r <= bus.ocode_i;
          end
        end
        ACCUM: begin
          // masked-off elements still advance the count but leave acc alone
          if (accept_s) begin
            cnt_r <= cnt_r + VL_ONE;
            if (active_s) begin
              acc_r <= bus.cmp_result_i;
            end
          end
        end
        DONE:    result_r <= acc_r;
        default: result_r <= result_r;
      endcase
    end
  end

  // Registered done/error pulses
  always_ff @(posedge module_clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= (state_r == DONE);
      err_r  <= in_idle_s & bus.start_i & ~legal_s;
    end
  end
endmodule

// File: tb/tb_vred_minmax_seq.sv
// Self-checking bench for vred_minmax_seq: directed cases plus randomized reductions
// against an extreme-value reference model; mask cases run when VRED_MASK_EN is defined.
module tb_vred_minmax_seq;
  localparam int DW  = 32;
  localparam int VLW = 6;
  localparam logic [6:0] OC_VMINU = 7'h09;
  localparam logic [6:0] OC_VMIN  = 7'h0B;
  localparam logic [6:0] OC_VMAXU = 7'h0D;
  localparam logic [6:0] OC_VMAX  = 7'h0F;
  localparam logic [6:0] OC_BAD   = 7'h31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] last_res = '0;
  logic [DW-1:0] elems[$];
  bit            masks[$];

  vred_minmax_seq_if #(.DATA_WIDTH(DW), .VL_W(VLW)) bus ();
  vred_minmax_seq #(.DATA_WIDTH(DW), .VL_W(VLW)) dut (
    .module_clk_i(clk),
    .rst_i       (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Comparator stand-in: returns min or max of a and b
  function automatic logic [DW-1:0] pick(input logic [6:0] oc, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (oc)
      OC_VMIN:  pick = ($signed(a) <= $signed(b)) ? a : b;
      OC_VMINU: pick = (a <= b) ? a : b;
      OC_VMAX:  pick = ($signed(a) >= $signed(b)) ? a : b;
      OC_VMAXU: pick = (a >= b) ? a : b;
      default:  pick = a;
    endcase
  endfunction

  assign bus.cmp_result_i = pick(bus.cmp_ocode_o, bus.cmp_a_o, bus.cmp_b_o);

  // Reference: extreme value over the scalar and every active element
  function automatic logic [DW-1:0] ref_red(input logic [6:0] oc, input logic [DW-1:0] scalar);
    logic [DW-1:0] best;
    best = scalar;
    foreach (elems[i]) begin
      if (masks[i]) begin
        case (oc)
          OC_VMIN:  if ($signed(elems[i]) < $signed(best)) best = elems[i];
          OC_VMINU: if (elems[i] < best) best = elems[i];
          OC_VMAX:  if ($signed(elems[i]) > $signed(best)) best = elems[i];
          OC_VMAXU: if (elems[i] > best) best = elems[i];
          default:  best = best;
        endcase
      end
    end
    return best;
  endfunction

  task automatic idle_inputs();
    bus.start_i      = 1'b0;
    bus.ocode_i      = 7'd0;
    bus.vl_i         = '0;
    bus.scalar_i     = '0;
    bus.elem_valid_i = 1'b0;
    bus.elem_data_i  = '0;
`ifdef VRED_MASK_EN
    bus.elem_mask_i  = 1'b0;
`endif
  endtask

  task automatic load_random(input int n);
    elems.delete();
    masks.delete();
    for (int i = 0; i < n; i++) begin
      elems.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom);
`ifdef VRED_MASK_EN
      masks.push_back(1'($urandom_range(0, 1)));
`else
      masks.push_back(1'b1);
`endif
    end
  endtask

  // One full reduction; poke drives extra starts while busy
  task automatic run_red(input string name, input logic [6:0] oc, input logic [DW-1:0] scalar,
                         input int gap_pct, input bit poke);
    int            vl, sent, cyc, done_cyc, budget;
    logic [DW-1:0] exp_res, exp_acc;
    bit            valid, act;
    vl       = elems.size();
    sent     = 0;
    done_cyc = -1;
    exp_acc  = scalar;
    exp_res  = ref_red(oc, scalar);
    budget   = vl * 4 + 20;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.ocode_i  = oc;
    bus.vl_i     = vl[VLW-1:0];
    bus.scalar_i = scalar;
    @(negedge clk);
    cyc = 1;
    while (done_cyc < 0 && cyc < budget) begin
      bus.start_i  = 1'b0;
      bus.scalar_i = $urandom;
      if (bus.done_o === 1'b1) begin
        done_cyc = cyc;
      end else begin
        tests++;
        if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL %s busy: busy_o=%b expected 1 (cycle %0d)", name, bus.busy_o, cyc); end
        tests++;
        if (bus.err_o !== 1'b0) begin fails++; $display("FAIL %s err: err_o=%b expected 0 (cycle %0d)", name, bus.err_o, cyc); end
        if (poke && cyc == 1) begin bus.start_i = 1'b1; bus.ocode_i = OC_BAD; end
        if (poke && cyc == 2) begin bus.start_i = 1'b1; bus.ocode_i = OC_VMAXU; end
        if (bus.elem_ready_o === 1'b1) begin
          if (sent >= vl) begin
            tests++; fails++;
            $display("FAIL %s overrun: elem_ready_o=1 expected 0 after %0d elements", name, sent);
            bus.elem_valid_i = 1'b0;
          end else begin
            valid = ($urandom_range(0, 99) >= gap_pct);
            act   = masks[sent];
            bus.elem_valid_i = valid;
            bus.elem_data_i  = elems[sent];
`ifdef VRED_MASK_EN
            bus.elem_mask_i  = act;
`endif
            #1;
            tests++;
            if (bus.cmp_a_o !== exp_acc) begin fails++; $display("FAIL %s cmp_a: cmp_a_o=%h expected %h", name, bus.cmp_a_o, exp_acc); end
            tests++;
            if (bus.cmp_en_o !== (valid & act)) begin fails++; $display("FAIL %s cmp_en: cmp_en_o=%b expected %b", name, bus.cmp_en_o, valid & act); end
            if (valid) begin
              if (act) exp_acc = pick(oc, exp_acc, elems[sent]);
              sent++;
            end
          end
        end else begin
          bus.elem_valid_i = 1'($urandom_range(0, 1));
          bus.elem_data_i  = $urandom;
          #1;
          tests++;
          if (bus.cmp_en_o !== 1'b0) begin fails++; $display("FAIL %s cmp_en_idle: cmp_en_o=%b expected 0", name, bus.cmp_en_o); end
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.start_i      = 1'b0;
    bus.elem_valid_i = 1'b0;
    tests++;
    if (done_cyc < 0) begin
      fails++;
      $display("FAIL %s timeout: done_o=0 expected 1 within %0d cycles", name, budget);
    end else begin
      tests++;
      if (bus.result_o !== exp_res) begin fails++; $display("FAIL %s result: result_o=%h expected %h", name, bus.result_o, exp_res); end
      tests++;
      if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL %s busy_at_done: busy_o=%b expected 0", name, bus.busy_o); end
      tests++;
      if (sent != vl) begin fails++; $display("FAIL %s consumed: %0d elements expected %0d", name, sent, vl); end
      if (gap_pct == 0) begin
        tests++;
        if (done_cyc != vl + 2) begin fails++; $display("FAIL %s latency: done_o at cycle %0d expected %0d", name, done_cyc, vl + 2); end
      end
      @(negedge clk);
      tests++;
      if (bus.done_o !== 1'b0 || bus.result_o !== exp_res) begin
        fails++;
        $display("FAIL %s hold: done_o=%b result_o=%h expected 0/%h", name, bus.done_o, bus.result_o, exp_res);
      end
      last_res = exp_res;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.elem_data_i = 32'hDEAD_BEEF;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.busy_o, bus.done_o, bus.err_o, bus.elem_ready_o, bus.cmp_en_o} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy/done/err/ready/cmp_en=%b expected 00000",
               {bus.busy_o, bus.done_o, bus.err_o, bus.elem_ready_o, bus.cmp_en_o});
    end
    tests++;
    if (bus.cmp_a_o !== '0 || bus.cmp_b_o !== '0 || bus.cmp_ocode_o !== 7'd0 || bus.result_o !== '0) begin
      fails++;
      $display("FAIL reset_data: cmp_a=%h cmp_b=%h cmp_ocode=%h result=%h expected all 0",
               bus.cmp_a_o, bus.cmp_b_o, bus.cmp_ocode_o, bus.result_o);
    end
    rst = 1'b0;
    bus.elem_data_i = '0;
    last_res = '0;
  endtask

  task automatic test_directed();
    elems = '{32'd7, 32'd12, 32'd3, 32'd9};
    masks = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_red("vredmin", OC_VMIN, 32'd10, 0, 1'b0);
    elems = '{32'hFFFF_FFFF, 32'd1, 32'd2};
    masks = '{1'b1, 1'b1, 1'b1};
    run_red("vredmaxu", OC_VMAXU, 32'd0, 0, 1'b0);
    run_red("vredmax", OC_VMAX, 32'd0, 0, 1'b0);
    run_red("vredminu", OC_VMINU, 32'd5, 0, 1'b0);
    elems.delete();
    masks.delete();
    run_red("vl_zero", OC_VMIN, 32'h55, 0, 1'b0);
  endtask

  task automatic test_mask();
`ifdef VRED_MASK_EN
    elems = '{32'd1, 32'd5, 32'd2};
    masks = '{1'b0, 1'b1, 1'b0};
    run_red("mask_min", OC_VMIN, 32'd8, 0, 1'b0);
`endif
  endtask

  task automatic test_illegal();
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.ocode_i  = OC_BAD;
    bus.vl_i     = 6'd3;
    bus.scalar_i = 32'h1234_5678;
    @(negedge clk);
    bus.start_i = 1'b0;
    tests++;
    if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      fails++; $display("FAIL illegal_pulse: err_o=%b busy_o=%b expected 1/0", bus.err_o, bus.busy_o);
    end
    @(negedge clk);
    tests++;
    if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.elem_ready_o !== 1'b0 || bus.result_o !== last_res) begin
      fails++;
      $display("FAIL illegal_after: err=%b busy=%b ready=%b result=%h expected 0/0/0/%h",
               bus.err_o, bus.busy_o, bus.elem_ready_o, bus.result_o, last_res);
    end
  endtask

  task automatic test_busy_start();
    elems = '{32'd40, 32'd3, 32'd77, 32'd21};
    masks = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_red("start_while_busy", OC_VMIN, 32'd50, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.ocode_i  = OC_VMIN;
    bus.vl_i     = 6'd4;
    bus.scalar_i = 32'd10;
    @(negedge clk);
    bus.start_i      = 1'b0;
    bus.elem_valid_i = 1'b1;
    bus.elem_data_i  = 32'd7;
`ifdef VRED_MASK_EN
    bus.elem_mask_i  = 1'b1;
`endif
    @(negedge clk);
    bus.elem_data_i = 32'd12;
    @(negedge clk);
    bus.elem_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.busy_o !== 1'b0 || bus.elem_ready_o !== 1'b0 || bus.cmp_en_o !== 1'b0) begin
      fails++; $display("FAIL rst_mid: busy=%b ready=%b cmp_en=%b expected 000", bus.busy_o, bus.elem_ready_o, bus.cmp_en_o);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) seen++;
    end
    tests++;
    if (seen != 0 || bus.result_o !== '0) begin
      fails++; $display("FAIL rst_mid_nodone: done pulses=%0d result_o=%h expected 0/0", seen, bus.result_o);
    end
    last_res = '0;
    elems = '{32'd7, 32'd12, 32'd3, 32'd9};
    masks = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_red("after_rst", OC_VMIN, 32'd10, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0] ops[4];
    ops = '{OC_VMIN, OC_VMINU, OC_VMAX, OC_VMAXU};
    for (int k = 0; k < 30; k++) begin
      load_random($urandom_range(0, 12));
      run_red("random", ops[$urandom_range(0, 3)], $urandom, (k % 3 == 0) ? 0 : 30, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_directed();
    test_mask();
    test_illegal();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
